muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file and consumes read_data1/read_data2 as rs1_data/rs2_data.
- Produces result for the register write-back mux.
- Multi-cycle: the core holds PC and the register-file write enable while the unit is busy.

---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants, state encoding and helpers for the RV32M multiply/divide unit.
// Holds M-extension decode values and the iteration count.
package muldiv_unit_pkg;

   localparam int XLEN        = 32;
   localparam int CNT_W       = 6;
   localparam int MULDIV_ITER = 32;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
      return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                               input logic          sgn);
      return sgn ? twos_neg(v) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the multiply/divide unit.
// The core is the master; the unit is the slave.
interface muldiv_unit_if;
   import muldiv_unit_pkg::*;

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, rs1_data, rs2_data, kill,
      input  busy, done, result
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data, kill,
      output busy, done, result
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide
// sharing one 64-bit shift register, 32 iterations per operation.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  bus
);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [2:0]        f3_q, f3_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              in_div, in_sa, in_sb, div_zero, div_ovf;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN:0]     mul_sum, div_rem, div_diff;
   logic              q_bit;
   logic [2*XLEN-1:0] mul_next, div_next, step_acc, prod_fix;
   logic [XLEN-1:0]   quo, rem, final_res;

   assign in_div = bus.funct3[2];
   assign in_sa  = bus.rs1_data[XLEN-1] &
                   (bus.funct3 == FUNCT3_MULH || bus.funct3 == FUNCT3_MULHSU ||
                    bus.funct3 == FUNCT3_DIV  || bus.funct3 == FUNCT3_REM);
   assign in_sb  = bus.rs2_data[XLEN-1] &
                   (bus.funct3 == FUNCT3_MULH || bus.funct3 == FUNCT3_DIV ||
                    bus.funct3 == FUNCT3_REM);
   assign abs_a  = abs_val(bus.rs1_data, in_sa);
   assign abs_b  = abs_val(bus.rs2_data, in_sb);

   assign div_zero = in_div && (bus.rs2_data == '0);
   assign div_ovf  = in_div && !bus.funct3[0] &&
                     (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.rs2_data == '1);

   // Multiply: add multiplicand into the high half, then shift right with carry
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // Divide: high half is the partial remainder, low half shifts in quotient bits
   assign div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_diff = div_rem - {1'b0, opb_q};
   assign q_bit    = ~div_diff[XLEN];
   assign div_next = {(q_bit ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0]),
                      acc_q[XLEN-2:0], q_bit};

   assign step_acc = f3_q[2] ? div_next : mul_next;
   assign prod_fix = (sa_q ^ sb_q) ? (~step_acc) + 64'd1 : step_acc;
   assign quo      = step_acc[XLEN-1:0];
   assign rem      = step_acc[2*XLEN-1:XLEN];

   always_comb begin
      final_res = '0;
      unique case (f3_q)
         FUNCT3_MUL:    final_res = prod_fix[XLEN-1:0];
         FUNCT3_MULH,
         FUNCT3_MULHSU,
         FUNCT3_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
         FUNCT3_DIV:    final_res = (sa_q ^ sb_q) ? twos_neg(quo) : quo;
         FUNCT3_DIVU:   final_res = quo;
         FUNCT3_REM:    final_res = sa_q ? twos_neg(rem) : rem;
         FUNCT3_REMU:   final_res = rem;
         default:       final_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      f3_d     = f3_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      result_d = result_q;
      unique case (state_q)
         MD_IDLE: begin
            if (bus.start && !bus.kill) begin
               f3_d  = bus.funct3;
               sa_d  = in_sa;
               sb_d  = in_sb;
               cnt_d = '0;
               if (div_zero) begin
                  result_d = bus.funct3[1] ? bus.rs1_data : '1;
                  state_d  = MD_DONE;
               end else if (div_ovf) begin
                  result_d = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                  state_d  = MD_DONE;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, (in_div ? abs_a : abs_b)};
                  opb_d   = in_div ? abs_b : abs_a;
                  state_d = MD_CALC;
               end
            end
         end
         MD_CALC: begin
            if (bus.kill) begin
               state_d = MD_IDLE;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MULDIV_ITER - 1)) begin
                  result_d = final_res;
                  state_d  = MD_DONE;
               end
            end
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         f3_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         f3_q     <= f3_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = (state_q != MD_IDLE);
   assign bus.done   = (state_q == MD_DONE);
   assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, kill, reset
// and continuous-start handshake.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errs   = 0;
   int   checks = 0;

   muldiv_unit_if bus();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
      int          first_done;
      int          done_cnt;
      int          busy_cnt;
      logic [31:0] res;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = f3;
      bus.rs1_data = a;
      bus.rs2_data = b;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.rs1_data = ~a;
      bus.rs2_data = b + 32'd1;
      first_done = -1;
      done_cnt   = 0;
      busy_cnt   = 0;
      res        = '0;
      for (int k = 0; k < 60; k++) begin
         if (bus.done) begin
            done_cnt++;
            if (first_done < 0) begin
               first_done = k;
               res        = bus.result;
            end
         end
         if (!bus.busy) break;
         busy_cnt++;
         @(posedge clk); #1;
      end
      chk({tag, " result"}, res, exp);
      chk({tag, " latency"}, first_done, exp_lat);
      chk({tag, " busy_cycles"}, busy_cnt, exp_lat + 1);
      chk({tag, " done_pulses"}, done_cnt, 1);
   endtask

   task automatic watch_no_done(input string tag, input int n);
      int seen;
      seen = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (bus.done) seen++;
      end
      chk(tag, seen, 0);
   endtask

   task automatic handshake_test;
      int          idx[2];
      logic [31:0] res[2];
      int          nd;
      int          idle_cnt;
      idx[0] = -1; idx[1] = -1;
      res[0] = '0; res[1] = '0;
      nd = 0;
      idle_cnt = 0;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = FUNCT3_MUL;
      bus.rs1_data = 32'd3;
      bus.rs2_data = 32'd5;
      @(posedge clk); #1;
      bus.rs1_data = 32'd6;
      bus.rs2_data = 32'd7;
      for (int k = 0; k < 100; k++) begin
         if (bus.done && nd < 2) begin
            idx[nd] = k;
            res[nd] = bus.result;
            nd++;
            if (nd == 2) bus.start = 1'b0;
         end
         if (!bus.busy && nd == 1) idle_cnt++;
         if (!bus.busy && nd == 2) break;
         if (k == 40) begin
            bus.rs1_data = 32'd100;
            bus.rs2_data = 32'd100;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      chk("hs first result", res[0], 32'd15);
      chk("hs second result", res[1], 32'd42);
      chk("hs first done idx", idx[0], 32);
      chk("hs second done idx", idx[1], 66);
      chk("hs idle gap", idle_cnt, 1);
   endtask

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.kill     = 1'b0;
      bus.funct3   = '0;
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
      chk("reset result", bus.result, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      run_op("mul", FUNCT3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32);
      run_op("mulh", FUNCT3_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 32);
      run_op("mulhu", FUNCT3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
      run_op("mulhsu", FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
      run_op("div", FUNCT3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32);
      run_op("rem", FUNCT3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32);
      run_op("divu", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 32);
      run_op("remu", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 32);

      run_op("divu0", FUNCT3_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 0);
      run_op("rem0", FUNCT3_REM, 32'd100, 32'd0, 32'd100, 0);
      run_op("div_ovf", FUNCT3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
      run_op("rem_ovf", FUNCT3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0);

      run_op("remu_pre", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 32);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = FUNCT3_DIV;
      bus.rs1_data = 32'd1000;
      bus.rs2_data = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      bus.kill = 1'b1;
      @(posedge clk); #1;
      bus.kill = 1'b0;
      chk("kill busy", bus.busy, 0);
      chk("kill done", bus.done, 0);
      watch_no_done("kill no_done", 40);
      chk("kill result held", bus.result, 32'd2);
      run_op("after_kill", FUNCT3_DIVU, 32'd1000, 32'd3, 32'd333, 32);

      @(negedge clk);
      bus.start    = 1'b1;
      bus.funct3   = FUNCT3_MUL;
      bus.rs1_data = 32'd3;
      bus.rs2_data = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst result", bus.result, 32'h0);
      watch_no_done("rst no_done", 40);
      run_op("after_rst", FUNCT3_MUL, 32'd3, 32'd4, 32'd12, 32);

      handshake_test();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
